// File: rtl/shift_unit_pipe.sv
// Two-stage pipelined shift/rotate unit with valid/ready flow control.
// S1 registers the request; S2 registers the computed result and flags.
module shift_unit_pipe #(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [AW-1:0]    amt,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    typedef enum logic [2:0] {
        OP_SRL = 3'b000,
        OP_SLL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROR = 3'b011,
        OP_ROL = 3'b100
    } op_e;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [AW-1:0]    s1_amt;
    logic [2:0]       s1_op;
    logic             s2_valid;
    logic             s2_load;

    // S2 can take a new entry when empty or when its current one drains;
    // S1 moves forward exactly when S2 loads.
    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign out_valid = s2_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the stages shift together without races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_amt   <= '0;
            s1_op    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= a;
                s1_amt <= amt;
                s1_op  <= op;
            end
        end
    end

    logic [AW-1:0]           amt_m1;
    logic [AW-1:0]           amt_neg;
    logic signed [WIDTH-1:0] sra_y;
    logic [WIDTH-1:0]        res_y;
    logic                    res_c;
    logic                    res_e;

    // amt_neg is (WIDTH - n) mod WIDTH, the complementary shift for rotates.
    assign amt_m1  = s1_amt - 1'b1;
    assign amt_neg = ~s1_amt + 1'b1;
    assign sra_y   = $signed(s1_a) >>> s1_amt;

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    always_comb begin
        res_y = s1_a;
        res_c = 1'b0;
        res_e = 1'b0;
        case (s1_op)
            OP_SRL: begin
                res_y = s1_a >> s1_amt;
                res_c = s1_a[amt_m1];
            end
            OP_SLL: begin
                res_y = s1_a << s1_amt;
                res_c = s1_a[amt_neg];
            end
            OP_SRA: begin
                res_y = sra_y;
                res_c = s1_a[amt_m1];
            end
            OP_ROR: begin
                res_y = (s1_a >> s1_amt) | (s1_a << amt_neg);
                res_c = res_y[WIDTH-1];
            end
            OP_ROL: begin
                res_y = (s1_a << s1_amt) | (s1_a >> amt_neg);
                res_c = res_y[0];
            end
            default: res_e = 1'b1;
        endcase
        if (s1_amt == '0) begin
            res_c = 1'b0;
        end
    end

    // Data registers only load with a valid entry, so results hold while
    // stalled and keep their last value after out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            y        <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            err      <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                y     <= res_y;
                carry <= res_c;
                zero  <= (res_y == '0);
                err   <= res_e;
            end
        end
    end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed scenarios on an 8-bit instance plus a randomized regression on a
// 32-bit instance against a bit-serial reference model.
module tb_shift_unit_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0] a8, y8;
    logic [2:0] amt8, op8;
    logic       carry8, zero8, err8;

    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] a32, y32;
    logic [4:0]  amt32;
    logic [2:0]  op32;
    logic        carry32, zero32, err32;

    shift_unit_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .amt(amt8), .op(op8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .y(y8), .carry(carry8), .zero(zero8), .err(err8)
    );

    shift_unit_pipe #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .amt(amt32), .op(op32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .y(y32), .carry(carry32), .zero(zero32), .err(err32)
    );

    typedef struct packed {
        logic [31:0] y;
        logic        c;
        logic        z;
        logic        e;
    } res32_t;

    // Bit-serial reference: shift one position at a time, tracking the last bit out.
    function automatic res32_t ref32(input logic [31:0] av, input int n, input logic [2:0] opv);
        logic [31:0] v = av;
        logic        c = 1'b0;
        logic        e = 1'b0;
        case (opv)
            3'd0: for (int i = 0; i < n; i++) begin c = v[0];  v = {1'b0, v[31:1]}; end
            3'd1: for (int i = 0; i < n; i++) begin c = v[31]; v = {v[30:0], 1'b0}; end
            3'd2: for (int i = 0; i < n; i++) begin c = v[0];  v = {v[31], v[31:1]}; end
            3'd3: begin
                for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
                c = (n != 0) ? v[31] : 1'b0;
            end
            3'd4: begin
                for (int i = 0; i < n; i++) v = {v[30:0], v[31]};
                c = (n != 0) ? v[0] : 1'b0;
            end
            default: e = 1'b1;
        endcase
        return {v, c, (v == 32'd0), e};
    endfunction

    task automatic test_reset();
        in_valid8 = 0; a8 = 0; amt8 = 0; op8 = 0; out_ready8 = 0;
        in_valid32 = 0; a32 = 0; amt32 = 0; op32 = 0; out_ready32 = 0;
        rst_n = 0;
        @(negedge clk);
        checks++;
        if ({out_valid8, y8, carry8, zero8, err8} !== 12'h000) begin
            errors++;
            $display("FAIL reset8: got %h want 000", {out_valid8, y8, carry8, zero8, err8});
        end
        checks++;
        if ({out_valid32, y32, carry32, zero32, err32} !== 36'h0) begin
            errors++;
            $display("FAIL reset32: got %h want 0", {out_valid32, y32, carry32, zero32, err32});
        end
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready8);
        end
    endtask

    task automatic test_sra();
        out_ready8 = 1;
        in_valid8 = 1; a8 = 8'h96; amt8 = 3; op8 = 3'b010;
        @(negedge clk);
        in_valid8 = 0;
        checks++;
        if (out_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL sra_early: out_valid got %b want 0", out_valid8);
        end
        @(negedge clk);
        checks++;
        if ({out_valid8, y8, carry8, zero8, err8} !== {1'b1, 8'hF2, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sra: got %h want %h", {out_valid8, y8, carry8, zero8, err8},
                     {1'b1, 8'hF2, 1'b1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  va [3] = '{8'h81, 8'h81, 8'h01};
        logic [2:0]  vo [3] = '{3'd4, 3'd1, 3'd0};
        logic [10:0] ex [3] = '{{8'h03, 3'b100}, {8'h02, 3'b100}, {8'h00, 3'b110}};
        out_ready8 = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2 && i < 5) begin
                checks++;
                if ({out_valid8, y8, carry8, zero8, err8} !== {1'b1, ex[i-2]}) begin
                    errors++;
                    $display("FAIL b2b[%0d]: got %h want %h", i - 2,
                             {out_valid8, y8, carry8, zero8, err8}, {1'b1, ex[i-2]});
                end
            end else if (i == 1 || i == 5) begin
                checks++;
                if (out_valid8 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle[%0d]: out_valid got %b want 0", i, out_valid8);
                end
            end
            in_valid8 = (i < 3);
            if (i < 3) begin a8 = va[i]; amt8 = 3'd1; op8 = vo[i]; end
        end
        in_valid8 = 0;
    endtask

    task automatic test_edge();
        logic [7:0]  va [8] = '{8'h5A, 8'h00, 8'h01, 8'h80, 8'h01, 8'h3C, 8'h5A, 8'hC0};
        logic [2:0]  vn [8] = '{3'd0, 3'd3, 3'd7, 3'd7, 3'd1, 3'd2, 3'd0, 3'd7};
        logic [2:0]  vo [8] = '{3'd0, 3'd7, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd0};
        logic [10:0] ex [8] = '{{8'h5A, 3'b000}, {8'h00, 3'b011}, {8'h80, 3'b000},
                               {8'hFF, 3'b000}, {8'h80, 3'b100}, {8'h3C, 3'b001},
                               {8'h5A, 3'b000}, {8'h01, 3'b100}};
        out_ready8 = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                checks++;
                if ({out_valid8, y8, carry8, zero8, err8} !== {1'b1, ex[i-2]}) begin
                    errors++;
                    $display("FAIL edge[%0d]: got %h want %h", i - 2,
                             {out_valid8, y8, carry8, zero8, err8}, {1'b1, ex[i-2]});
                end
            end
            in_valid8 = (i < 8);
            if (i < 8) begin a8 = va[i]; amt8 = vn[i]; op8 = vo[i]; end
        end
        in_valid8 = 0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [8:0] got[$];
        logic [8:0] ex [3] = '{{8'h0F, 1'b1}, {8'hF0, 1'b1}, {8'h21, 1'b0}};
        out_ready8 = 0;
        in_valid8 = 1; a8 = 8'hF8; amt8 = 4; op8 = 3'd0;
        #1;
        checks++;
        if (in_ready8 !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b want 1", in_ready8); end
        @(negedge clk);
        a8 = 8'h1F; amt8 = 4; op8 = 3'd1;
        #1;
        checks++;
        if (in_ready8 !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", in_ready8); end
        @(negedge clk);
        a8 = 8'h12; amt8 = 4; op8 = 3'd3;
        #1;
        checks++;
        if ({in_ready8, out_valid8, y8, carry8} !== {1'b0, 1'b1, 8'h0F, 1'b1}) begin
            errors++;
            $display("FAIL bp_full: got %h want %h", {in_ready8, out_valid8, y8, carry8},
                     {1'b0, 1'b1, 8'h0F, 1'b1});
        end
        @(negedge clk);
        checks++;
        if ({in_ready8, out_valid8, y8, carry8} !== {1'b0, 1'b1, 8'h0F, 1'b1}) begin
            errors++;
            $display("FAIL bp_hold: got %h want %h", {in_ready8, out_valid8, y8, carry8},
                     {1'b0, 1'b1, 8'h0F, 1'b1});
        end
        out_ready8 = 1;
        #1;
        checks++;
        if (in_ready8 !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready got %b want 1", in_ready8); end
        if (out_valid8) got.push_back({y8, carry8});
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid8 = 0;
            if (out_valid8) got.push_back({y8, carry8});
        end
        checks++;
        if (got.size() !== 3) begin
            errors++;
            $display("FAIL bp_count: got %0d results want 3", got.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (((i < got.size()) ? got[i] : 9'bx) !== ex[i]) begin
                errors++;
                $display("FAIL bp_order[%0d]: got %h want %h", i,
                         (i < got.size()) ? got[i] : 9'bx, ex[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready8 = 0;
        in_valid8 = 1; a8 = 8'h01; amt8 = 1; op8 = 3'd1;
        @(negedge clk);
        a8 = 8'h40; amt8 = 2; op8 = 3'd0;
        @(negedge clk);
        in_valid8 = 0;
        #1;
        checks++;
        if ({out_valid8, y8} !== {1'b1, 8'h02}) begin
            errors++;
            $display("FAIL rm_before: got %h want %h", {out_valid8, y8}, {1'b1, 8'h02});
        end
        #1 rst_n = 0;
        #1;
        checks++;
        if ({out_valid8, y8, carry8, zero8, err8} !== 12'h000) begin
            errors++;
            $display("FAIL rm_async: got %h want 000", {out_valid8, y8, carry8, zero8, err8});
        end
        @(negedge clk);
        rst_n = 1;
        out_ready8 = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid8 !== 1'b0) begin
                errors++;
                $display("FAIL rm_stale[%0d]: out_valid got %b want 0", k, out_valid8);
            end
        end
    endtask

    task automatic test_random32();
        res32_t q[$];
        res32_t exp_r, got_r;
        int     sent = 0;
        int     cyc = 0;
        int     op_hits[8] = '{default: 0};
        int     amt0 = 0;
        int     amt31 = 0;
        int     r;
        logic   acc = 1'b0;
        logic   covered;
        in_valid32 = 0;
        while ((sent < 10000 || q.size() > 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (acc) in_valid32 = 0;
            if (!in_valid32 && sent < 10000 && $urandom_range(0, 4) != 0) begin
                a32 = $urandom;
                r = $urandom_range(0, 9);
                amt32 = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom_range(0, 31));
                op32 = 3'($urandom_range(0, 7));
                in_valid32 = 1;
            end
            out_ready32 = ($urandom_range(0, 9) < 7);
            #1;
            if (out_valid32 && out_ready32) begin
                got_r = {y32, carry32, zero32, err32};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra: got %h want no result", got_r);
                end else begin
                    exp_r = q.pop_front();
                    if (got_r !== exp_r) begin
                        errors++;
                        $display("FAIL rnd: got %h want %h", got_r, exp_r);
                    end
                end
            end
            acc = in_valid32 && in_ready32;
            if (acc) begin
                q.push_back(ref32(a32, int'(amt32), op32));
                sent++;
                op_hits[op32]++;
                if (amt32 == 5'd0)  amt0++;
                if (amt32 == 5'd31) amt31++;
            end
        end
        in_valid32 = 0;
        checks++;
        if (sent != 10000 || q.size() != 0) begin
            errors++;
            $display("FAIL rnd_timeout: sent %0d pending %0d want 10000 and 0", sent, q.size());
        end
        covered = (amt0 > 0) && (amt31 > 0);
        for (int i = 0; i < 8; i++) covered &= (op_hits[i] > 0);
        checks++;
        if (!covered) begin
            errors++;
            $display("FAIL rnd_coverage: amt0=%0d amt31=%0d want both nonzero and all ops hit", amt0, amt31);
        end
    endtask

    initial begin
        test_reset();
        test_sra();
        test_back_to_back();
        test_edge();
        test_backpressure();
        test_reset_mid();
        test_random32();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
